// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared state encoding and Ethernet framing constants
package eth_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PAD
  } eth_state_e;

  localparam logic [15:0] ETH_TYPE_MIN     = 16'h0600;
  localparam int          ETH_HEADER_BYTES = 14;
  localparam int          ETH_MIN_PAYLOAD  = 46;
  localparam int          ETH_MAX_PAYLOAD  = 1500;

endpackage

// File: rtl/eth_frame_sequencer.sv
// rtl/eth_frame_sequencer.sv - frame tracking, header/payload enables and type/length enforcement
module eth_frame_sequencer
  import eth_pkg::*;
#(
  parameter int HEADER_BYTES = ETH_HEADER_BYTES,
  parameter int MIN_PAYLOAD  = ETH_MIN_PAYLOAD,
  parameter int MAX_PAYLOAD  = ETH_MAX_PAYLOAD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        control,
  input  logic [7:0]  data,
  output logic        enable_header,
  output logic        enable_payload,
  output logic [15:0] type_length,
  output logic        is_length,
  output logic [10:0] payload_count,
  output logic        frame_done,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [3:0]  MSB_IDX  = 4'(HEADER_BYTES - 2);
  localparam logic [3:0]  LSB_IDX  = 4'(HEADER_BYTES - 1);
  localparam logic [10:0] MAX_POST = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MIN_POST = 11'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);

  eth_state_e  state;
  logic [3:0]  hdr_cnt;
  logic [10:0] post_cnt;
  logic [7:0]  msb;
  logic [15:0] field;
  logic        at_limit;

  assign field    = {msb, data};
  assign at_limit = (post_cnt == MAX_POST);

  // A byte that would overflow the post-header budget gets no enable.
  assign enable_header  = control & ((state == ST_IDLE) | (state == ST_HEADER));
  assign enable_payload = control & (state == ST_PAYLOAD) & ~at_limit;
  assign busy           = (state != ST_IDLE) & (state != ST_DRAIN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_DRAIN;
      hdr_cnt       <= '0;
      post_cnt      <= '0;
      msb           <= '0;
      type_length   <= '0;
      is_length     <= 1'b0;
      payload_count <= '0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        ST_DRAIN: begin
          if (!control) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (control) begin
            hdr_cnt       <= 4'd1;
            post_cnt      <= '0;
            payload_count <= '0;
            state         <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (control) begin
            hdr_cnt <= hdr_cnt + 4'd1;
            if (hdr_cnt == MSB_IDX) msb <= data;
            if (hdr_cnt == LSB_IDX) begin
              type_length <= field;
              is_length   <= (field <= MAX_LEN);
              if (field >= ETH_TYPE_MIN || (field != 16'd0 && field <= MAX_LEN)) begin
                state <= ST_PAYLOAD;
              end else if (field == 16'd0) begin
                state <= ST_PAD;
              end else begin
                frame_error <= 1'b1;
                state       <= ST_DRAIN;
              end
            end
          end else begin
            frame_error <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_PAYLOAD, ST_PAD: begin
          if (control) begin
            if (at_limit) begin
              frame_error <= 1'b1;
              state       <= ST_DRAIN;
            end else begin
              post_cnt <= post_cnt + 11'd1;
              if (state == ST_PAYLOAD) begin
                payload_count <= payload_count + 11'd1;
                if (is_length && (16'(payload_count) + 16'd1 == type_length)) state <= ST_PAD;
              end
            end
          end else begin
            // Length-mode frames still in PAYLOAD never reached their declared length.
            if (post_cnt < MIN_POST || (is_length && state == ST_PAYLOAD)) frame_error <= 1'b1;
            else frame_done <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_sequencer.sv
// tb/tb_eth_frame_sequencer.sv - randomized frame stimulus against a per-frame outcome model
module tb_eth_frame_sequencer;

  localparam int HDR  = 14;
  localparam int MINP = 46;
  localparam int MAXP = 1500;

  logic        clock = 1'b0;
  logic        reset;
  logic        control;
  logic [7:0]  data;
  logic        enable_header;
  logic        enable_payload;
  logic [15:0] type_length;
  logic        is_length;
  logic [10:0] payload_count;
  logic        frame_done;
  logic        frame_error;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  eth_frame_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .control        (control),
    .data           (data),
    .enable_header  (enable_header),
    .enable_payload (enable_payload),
    .type_length    (type_length),
    .is_length      (is_length),
    .payload_count  (payload_count),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive one byte slot; enables sampled mid-cycle, pulses just after the edge that registers them.
  task automatic step(input logic c, input logic [7:0] d,
                      output logic eh, output logic ep, output logic fd, output logic fe);
    @(negedge clock);
    control = c;
    data    = d;
    #1;
    eh = enable_header;
    ep = enable_payload;
    @(posedge clock);
    #1;
    fd = frame_done;
    fe = frame_error;
  endtask

  task automatic run_frame(input string name, input int len, input logic [15:0] v, input int gap);
    int  post, pay, vi, exp_idx, idx, n_pay, n_done, n_err, bad_en;
    bit  has_hdr, invalid, len_mode, exp_done;
    logic eh, ep, fd, fe;
    logic [7:0] d;
    vi       = int'(v);
    post     = len - HDR;
    has_hdr  = (len >= HDR);
    invalid  = has_hdr && vi > MAXP && vi < 'h0600;
    len_mode = (vi <= MAXP);
    exp_done = 1'b0;
    pay      = 0;
    if (!has_hdr) begin
      exp_idx = len;
    end else if (invalid) begin
      exp_idx = HDR - 1;
    end else begin
      pay = post;
      if (len_mode && vi < pay) pay = vi;
      if (pay > MAXP) pay = MAXP;
      if (post > MAXP) exp_idx = HDR + MAXP;
      else begin
        exp_idx  = len;
        exp_done = !(post < MINP || (len_mode && post < vi));
      end
    end
    idx = -1; n_pay = 0; n_done = 0; n_err = 0; bad_en = 0;
    for (int k = 0; k < len + gap; k++) begin
      if (k == HDR - 2)      d = v[15:8];
      else if (k == HDR - 1) d = v[7:0];
      else                   d = 8'($urandom);
      step(k < len, d, eh, ep, fd, fe);
      if (eh !== (k < len && k < HDR)) bad_en++;
      if (ep !== (k >= HDR && k < HDR + pay)) bad_en++;
      if (ep === 1'b1) n_pay++;
      if (fd === 1'b1) begin n_done++; idx = k; end
      if (fe === 1'b1) begin n_err++;  idx = k; end
    end
    check_eq({name, " enable_pattern_errs"}, bad_en, 0);
    check_eq({name, " payload_enables"}, n_pay, pay);
    check_eq({name, " done_pulses"}, n_done, exp_done ? 1 : 0);
    check_eq({name, " error_pulses"}, n_err, exp_done ? 0 : 1);
    check_eq({name, " pulse_cycle"}, idx, exp_idx);
    check_eq({name, " payload_count"}, int'(payload_count), pay);
    check_eq({name, " busy_after"}, int'(busy), 0);
    if (has_hdr) check_eq({name, " type_length"}, int'(type_length), vi);
    if (has_hdr && !invalid) check_eq({name, " is_length"}, int'(is_length), len_mode ? 1 : 0);
  endtask

  initial begin
    logic eh, ep, fd, fe;
    int   acc_en, acc_pulse, r, len;
    logic [15:0] v;

    reset   = 1'b1;
    control = 1'b1;
    data    = 8'h00;
    repeat (2) step(1'b1, 8'h55, eh, ep, fd, fe);
    check_eq("reset enable_header", int'(eh), 0);
    check_eq("reset enable_payload", int'(ep), 0);
    check_eq("reset frame_done", int'(fd), 0);
    check_eq("reset frame_error", int'(fe), 0);
    check_eq("reset type_length", int'(type_length), 0);
    check_eq("reset is_length", int'(is_length), 0);
    check_eq("reset payload_count", int'(payload_count), 0);
    check_eq("reset busy", int'(busy), 0);
    reset = 1'b0;
    step(1'b0, 8'h00, eh, ep, fd, fe);

    run_frame("type_frame", HDR + 46, 16'h0800, 1);
    run_frame("length_frame", HDR + 46, 16'h0010, 2);
    run_frame("runt", 10, 16'h0800, 2);
    run_frame("invalid_05ff", HDR + 46, 16'h05FF, 1);
    run_frame("invalid_05dd", HDR + 46, 16'h05DD, 1);
    run_frame("oversize", HDR + 1501, 16'h0800, 1);
    run_frame("back_to_back", HDR + 64, 16'h0800, 1);
    run_frame("zero_len_min", HDR + 46, 16'h0000, 1);
    run_frame("zero_len_short", HDR + 45, 16'h0000, 1);
    run_frame("type_max", HDR + 1500, 16'h0600, 1);
    run_frame("length_max", HDR + 1500, 16'd1500, 1);
    run_frame("length_short", HDR + 49, 16'd50, 1);
    run_frame("header_only", HDR, 16'h0800, 1);
    run_frame("length_over_oversize", HDR + 1502, 16'd100, 1);

    for (int k = 0; k < 20; k++) begin
      if (k == HDR - 2)      step(1'b1, 8'h08, eh, ep, fd, fe);
      else if (k == HDR - 1) step(1'b1, 8'h00, eh, ep, fd, fe);
      else                   step(1'b1, 8'($urandom), eh, ep, fd, fe);
    end
    reset = 1'b1;
    step(1'b1, 8'hAA, eh, ep, fd, fe);
    reset     = 1'b0;
    acc_pulse = int'(fd) + int'(fe);
    acc_en    = 0;
    repeat (5) begin
      step(1'b1, 8'($urandom), eh, ep, fd, fe);
      acc_en    += int'(eh) + int'(ep);
      acc_pulse += int'(fd) + int'(fe);
    end
    step(1'b0, 8'h00, eh, ep, fd, fe);
    acc_pulse += int'(fd) + int'(fe);
    check_eq("midreset enables", acc_en, 0);
    check_eq("midreset pulses", acc_pulse, 0);
    check_eq("midreset payload_count", int'(payload_count), 0);
    run_frame("after_reset", HDR + 60, 16'h86DD, 1);

    for (int f = 0; f < 40; f++) begin
      r = int'($urandom % 6);
      case (r)
        0: v = 16'h0800;
        1: v = 16'($urandom_range(1, 1500));
        2: v = 16'h0000;
        3: v = 16'($urandom_range(1501, 1535));
        4: v = 16'($urandom_range(16'h0600, 16'hFFFF));
        default: v = 16'($urandom_range(40, 80));
      endcase
      r = int'($urandom % 10);
      if (r == 0)      len = int'($urandom_range(1, HDR));
      else if (r == 1) len = int'($urandom_range(HDR + 1498, HDR + 1504));
      else             len = int'($urandom_range(HDR + 30, HDR + 120));
      run_frame($sformatf("rand%0d", f), len, v, int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
